// File: rtl/if_prefetch.sv
// Instruction prefetch buffer: issues sequential fetches, queues returned words with their PCs,
// and flushes on redirect while discarding responses to requests issued before the redirect.
module if_prefetch #(
  parameter int               XLEN     = 32,
  parameter int               DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] inst_pc_plus4
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  // Repeated redirects can stack discards beyond DEPTH, so this counter gets headroom.
  localparam int DW = AW + 4;

  logic            run_reg;
  logic [XLEN-1:0] fetch_pc_reg;
  logic [XLEN-1:0] tail_pc_reg;
  logic [AW-1:0]   head_ptr_reg;
  logic [AW-1:0]   tail_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic [CW-1:0]   outst_reg;
  logic [DW-1:0]   discard_reg;

  logic [XLEN-1:0] data_mem [DEPTH];
  logic [XLEN-1:0] pc_mem   [DEPTH];

  logic [CW:0]     inflight;
  logic            req_xfer;
  logic            rsp_drop;
  logic            rsp_take;
  logic            enq;
  logic            deq;
  logic [XLEN-1:0] redirect_pc_aligned;
  logic [CW-1:0]   outst_next;
  logic [DW-1:0]   discard_next;
  logic [CW-1:0]   count_next;
  logic            unused_pc_bits;

  assign unused_pc_bits      = ^redirect_pc[1:0];
  assign redirect_pc_aligned = {redirect_pc[XLEN-1:2], 2'b00};

  // Occupancy plus outstanding bounds issue so every in-flight response owns a slot.
  assign inflight       = {1'b0, count_reg} + {1'b0, outst_reg};
  assign imem_req_valid = run_reg && !redirect && (inflight < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_reg;
  assign req_xfer       = imem_req_valid && imem_req_ready;

  assign rsp_drop = imem_rsp_valid && (discard_reg != '0);
  assign rsp_take = imem_rsp_valid && (discard_reg == '0) && (outst_reg != '0);
  assign enq      = rsp_take && !redirect;

  assign inst_valid    = (count_reg != '0);
  assign deq           = inst_valid && inst_ready && !redirect;
  assign inst_data     = inst_valid ? data_mem[head_ptr_reg] : '0;
  assign inst_pc       = inst_valid ? pc_mem[head_ptr_reg] : '0;
  assign inst_pc_plus4 = inst_valid ? pc_mem[head_ptr_reg] + XLEN'(4) : '0;

  always_comb begin
    discard_next = discard_reg - DW'(rsp_drop);
    outst_next   = outst_reg + CW'(req_xfer) - CW'(rsp_take);
    count_next   = count_reg + CW'(enq) - CW'(deq);
    if (redirect) begin
      // A response accepted during the redirect cycle retires its own outstanding slot.
      discard_next = discard_next + DW'(outst_reg) + DW'(req_xfer) - DW'(rsp_take);
      outst_next   = '0;
      count_next   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_reg      <= 1'b0;
      fetch_pc_reg <= RESET_PC;
      tail_pc_reg  <= RESET_PC;
      head_ptr_reg <= '0;
      tail_ptr_reg <= '0;
      count_reg    <= '0;
      outst_reg    <= '0;
      discard_reg  <= '0;
    end else begin
      run_reg     <= 1'b1;
      count_reg   <= count_next;
      outst_reg   <= outst_next;
      discard_reg <= discard_next;
      if (redirect) begin
        fetch_pc_reg <= redirect_pc_aligned;
        tail_pc_reg  <= redirect_pc_aligned;
        head_ptr_reg <= '0;
        tail_ptr_reg <= '0;
      end else begin
        if (req_xfer) fetch_pc_reg <= fetch_pc_reg + XLEN'(4);
        if (enq) begin
          tail_pc_reg  <= tail_pc_reg + XLEN'(4);
          tail_ptr_reg <= tail_ptr_reg + AW'(1);
        end
        if (deq) head_ptr_reg <= head_ptr_reg + AW'(1);
      end
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (enq && (tail_ptr_reg == AW'(gi))) begin
          data_mem[gi] <= imem_rsp_data;
          pc_mem[gi]   <= tail_pc_reg;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch: per-cycle vector tables against a latency-configurable memory
// model, plus hand sequences for address wrap and asynchronous reset.
module tb_if_prefetch;

  localparam logic [31:0] KEY = 32'hDEAD_BEEF;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] w_rsp_data;
  logic        inst_ready;

  logic        imem_req_valid, inst_valid;
  logic [31:0] imem_req_addr, inst_data, inst_pc, inst_pc_plus4;
  logic        w_req_valid, w_inst_valid;
  logic [31:0] w_req_addr, w_inst_data, w_inst_pc, w_inst_pc_plus4;

  if_prefetch #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) u_dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc), .inst_pc_plus4(inst_pc_plus4)
  );

  if_prefetch #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(w_rsp_data), .inst_valid(w_inst_valid), .inst_ready(inst_ready),
    .inst_data(w_inst_data), .inst_pc(w_inst_pc), .inst_pc_plus4(w_inst_pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst_first;
    int          lat;
    bit          rdy;
    bit          redir;
    logic [31:0] rpc;
    bit          exp_iv;
    logic [31:0] exp_pc;
    bit          exp_rv;
    logic [31:0] exp_ra;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] wa;
    int          due;
  } pend_t;

  vec_t  tbl[$];
  pend_t q[$];
  int    cyc;
  int    lat;
  int    checks;
  int    errors;

  logic        obs_iv, obs_rv, w_iv;
  logic [31:0] obs_pc, obs_data, obs_pc4, obs_ra, w_pc, w_data, w_pc4, w_ra;

  task automatic add(input bit r, input int l, input bit rdy, input bit rd, input logic [31:0] rpc,
                     input bit iv, input logic [31:0] pc, input bit rv, input logic [31:0] ra);
    vec_t v;
    v.rst_first = r; v.lat = l; v.rdy = rdy; v.redir = rd; v.rpc = rpc;
    v.exp_iv = iv; v.exp_pc = pc; v.exp_rv = rv; v.exp_ra = ra;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic do_reset(input bit clear);
    rst = 1'b1;
    imem_rsp_valid = 1'b0;
    redirect = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    if (clear) q.delete();
  endtask

  // Called at a falling edge: drive inputs, sample settled outputs, advance one clock.
  task automatic step(input bit rdy, input bit redir, input logic [31:0] rpc);
    pend_t p;
    inst_ready = rdy;
    redirect = redir;
    redirect_pc = rpc;
    if (q.size() > 0 && q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data = q[0].a ^ KEY;
      w_rsp_data = q[0].wa ^ KEY;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data = '0;
      w_rsp_data = '0;
    end
    #1;
    obs_iv = inst_valid; obs_pc = inst_pc; obs_data = inst_data; obs_pc4 = inst_pc_plus4;
    obs_rv = imem_req_valid; obs_ra = imem_req_addr;
    w_iv = w_inst_valid; w_pc = w_inst_pc; w_data = w_inst_data; w_pc4 = w_inst_pc_plus4;
    w_rv_ra_capture();
    if (imem_req_valid && imem_req_ready) begin
      p.a = imem_req_addr; p.wa = w_req_addr; p.due = cyc + lat;
      q.push_back(p);
    end
    if (imem_rsp_valid) void'(q.pop_front());
    $display("cyc %0d rdy %0b redir %0b iv %0b pc %h data %h rv %0b ra %h",
             cyc, rdy, redir, obs_iv, obs_pc, obs_data, obs_rv, obs_ra);
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic w_rv_ra_capture();
    w_ra = w_req_addr;
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; lat = 1;
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; w_rsp_data = '0; inst_ready = 1'b0;

    // Streaming, 1-cycle memory, decode always ready.
    add(1,1,1,0,0, 0,32'h00, 0,32'h00);
    add(0,1,1,0,0, 0,32'h00, 1,32'h00);
    add(0,1,1,0,0, 0,32'h00, 1,32'h04);
    add(0,1,1,0,0, 1,32'h00, 1,32'h08);
    add(0,1,1,0,0, 1,32'h04, 1,32'h0C);
    add(0,1,1,0,0, 1,32'h08, 1,32'h10);
    add(0,1,1,0,0, 1,32'h0C, 1,32'h14);
    add(0,1,1,0,0, 1,32'h10, 1,32'h18);
    // Back-pressure: four entries fill, issue stops, order intact on release.
    add(1,1,0,0,0, 0,32'h00, 0,32'h00);
    add(0,1,0,0,0, 0,32'h00, 1,32'h00);
    add(0,1,0,0,0, 0,32'h00, 1,32'h04);
    add(0,1,0,0,0, 1,32'h00, 1,32'h08);
    add(0,1,0,0,0, 1,32'h00, 1,32'h0C);
    add(0,1,0,0,0, 1,32'h00, 0,32'h10);
    add(0,1,0,0,0, 1,32'h00, 0,32'h10);
    add(0,1,0,0,0, 1,32'h00, 0,32'h10);
    add(0,1,1,0,0, 1,32'h00, 0,32'h10);
    add(0,1,1,0,0, 1,32'h04, 1,32'h10);
    add(0,1,1,0,0, 1,32'h08, 1,32'h14);
    add(0,1,1,0,0, 1,32'h0C, 1,32'h18);
    add(0,1,1,0,0, 1,32'h10, 1,32'h1C);
    add(0,1,1,0,0, 1,32'h14, 1,32'h20);
    // Redirect to 0x103 with two requests in flight (3-cycle memory).
    add(1,3,1,0,0,          0,32'h000, 0,32'h000);
    add(0,3,1,0,0,          0,32'h000, 1,32'h000);
    add(0,3,1,0,0,          0,32'h000, 1,32'h004);
    add(0,3,1,1,32'h103,    0,32'h000, 0,32'h008);
    add(0,3,1,0,0,          0,32'h000, 1,32'h100);
    add(0,3,1,0,0,          0,32'h000, 1,32'h104);
    add(0,3,1,0,0,          0,32'h000, 1,32'h108);
    add(0,3,1,0,0,          0,32'h000, 1,32'h10C);
    add(0,3,1,0,0,          1,32'h100, 0,32'h110);
    add(0,3,1,0,0,          1,32'h104, 1,32'h110);
    add(0,3,1,0,0,          1,32'h108, 1,32'h114);
    add(0,3,1,0,0,          1,32'h10C, 1,32'h118);
    // Redirect coinciding with a response and a dequeue.
    add(1,1,1,0,0,          0,32'h000, 0,32'h000);
    add(0,1,1,0,0,          0,32'h000, 1,32'h000);
    add(0,1,1,0,0,          0,32'h000, 1,32'h004);
    add(0,1,1,0,0,          1,32'h000, 1,32'h008);
    add(0,1,1,1,32'h200,    1,32'h004, 0,32'h00C);
    add(0,1,1,0,0,          0,32'h000, 1,32'h200);
    add(0,1,1,0,0,          0,32'h000, 1,32'h204);
    add(0,1,1,0,0,          1,32'h200, 1,32'h208);
    add(0,1,1,0,0,          1,32'h204, 1,32'h20C);

    @(negedge clk);
    foreach (tbl[i]) begin
      if (tbl[i].rst_first) begin
        lat = tbl[i].lat;
        do_reset(1'b1);
      end
      step(tbl[i].rdy, tbl[i].redir, tbl[i].rpc);
      chk("inst_valid", i, {31'b0, obs_iv}, {31'b0, tbl[i].exp_iv});
      chk("inst_pc", i, obs_pc, tbl[i].exp_iv ? tbl[i].exp_pc : 32'h0);
      chk("inst_data", i, obs_data, tbl[i].exp_iv ? (tbl[i].exp_pc ^ KEY) : 32'h0);
      chk("inst_pc_plus4", i, obs_pc4, tbl[i].exp_iv ? (tbl[i].exp_pc + 32'd4) : 32'h0);
      chk("req_valid", i, {31'b0, obs_rv}, {31'b0, tbl[i].exp_rv});
      chk("req_addr", i, obs_ra, tbl[i].exp_ra);
    end

    // Address wrap on the RESET_PC=0xFFFFFFF8 instance.
    lat = 1;
    do_reset(1'b1);
    step(1, 0, 0);
    step(1, 0, 0);  chk("wrap_ra_c1", 0, w_ra, 32'hFFFF_FFF8);
    step(1, 0, 0);
    step(1, 0, 0);  chk("wrap_pc_c3", 0, w_pc, 32'hFFFF_FFF8);
                    chk("wrap_ra_c3", 0, w_ra, 32'h0000_0000);
                    chk("wrap_data_c3", 0, w_data, 32'hFFFF_FFF8 ^ KEY);
    step(1, 0, 0);  chk("wrap_pc_c4", 0, w_pc, 32'hFFFF_FFFC);
                    chk("wrap_pc4_c4", 0, w_pc4, 32'h0000_0000);
    step(1, 0, 0);  chk("wrap_pc_c5", 0, w_pc, 32'h0000_0000);
                    chk("wrap_iv_c5", 0, {31'b0, w_iv}, 32'h1);
                    chk("wrap_data_c5", 0, w_data, 32'h0 ^ KEY);

    // Asynchronous reset between edges with a response still in flight.
    #2;
    rst = 1'b1;
    imem_rsp_valid = 1'b0;
    #1;
    chk("arst_req_valid", 0, {31'b0, imem_req_valid}, 32'h0);
    chk("arst_req_addr", 0, imem_req_addr, 32'h0);
    chk("arst_inst_valid", 0, {31'b0, inst_valid}, 32'h0);
    chk("arst_inst_data", 0, inst_data, 32'h0);
    chk("arst_inst_pc", 0, inst_pc, 32'h0);
    chk("arst_inst_pc4", 0, inst_pc_plus4, 32'h0);
    chk("arst_wrap_addr", 0, w_req_addr, 32'hFFFF_FFF8);
    @(negedge clk);
    rst = 1'b0;
    step(1, 0, 0);  chk("post_rst_rv_c0", 0, {31'b0, obs_rv}, 32'h0);
                    chk("post_rst_iv_c0", 0, {31'b0, obs_iv}, 32'h0);
    step(1, 0, 0);  chk("post_rst_rv_c1", 0, {31'b0, obs_rv}, 32'h1);
                    chk("post_rst_ra_c1", 0, obs_ra, 32'h0);
    step(1, 0, 0);  chk("post_rst_iv_c2", 0, {31'b0, obs_iv}, 32'h0);
    step(1, 0, 0);  chk("post_rst_pc_c3", 0, obs_pc, 32'h0);
                    chk("post_rst_data_c3", 0, obs_data, 32'h0 ^ KEY);
                    chk("post_rst_iv_c3", 0, {31'b0, obs_iv}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_prefetch.md
IF_PREFETCH -- requirements
Module: if_prefetch

Interface
- REQ-001: The block SHALL have parameter XLEN, default 32, giving the instruction and address width in bits.
- REQ-002: The block SHALL have parameter DEPTH, default 4, giving the prefetch-buffer entries; it SHALL be a power of two, at least 2.
- REQ-003: The block SHALL have parameter RESET_PC, default 0, giving the first fetch address after reset.
- REQ-004: The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-005: The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
- REQ-006: The block SHALL have port redirect, input, 1 bit: a taken branch or jump; flushes the buffer and reloads the PC.
- REQ-007: The block SHALL have port redirect_pc, input, XLEN bits: the target address, qualified by redirect.
- REQ-008: The block SHALL have port imem_req_valid, output, 1 bit: a fetch request is presented.
- REQ-009: The block SHALL have port imem_req_addr, output, XLEN bits: the fetch address.
- REQ-010: The block SHALL have port imem_req_ready, input, 1 bit: memory accepts the request this cycle.
- REQ-011: The block SHALL have port imem_rsp_valid, input, 1 bit: read data is returned, in request order.
- REQ-012: The block SHALL have port imem_rsp_data, input, XLEN bits: the instruction word.
- REQ-013: The block SHALL have port inst_valid, output, 1 bit: the buffer head holds an instruction.
- REQ-014: The block SHALL have port inst_ready, input, 1 bit: the decode stage accepts the head.
- REQ-015: The block SHALL have ports inst_data, inst_pc and inst_pc_plus4, outputs, XLEN bits each: the instruction, its address and its address + 4.

Function
- REQ-016: A request SHALL transfer when imem_req_valid and imem_req_ready are both high on a rising edge.
- REQ-017: imem_req_valid SHALL be high exactly when (occupancy + outstanding) < DEPTH and redirect is low, so that every in-flight response has a reserved slot.
- REQ-018: imem_req_addr SHALL equal fetch_pc; on each transfer, fetch_pc SHALL advance by 4, modulo 2^XLEN, so 0xFFFFFFFC wraps to 0x00000000.
- REQ-019: A non-discarded response SHALL be written at the buffer tail with its PC; the PC tail pointer SHALL advance by 4 per enqueue.
- REQ-020: A dequeue SHALL occur when inst_valid and inst_ready are both high; inst_* SHALL be driven combinationally from the head entry.
- REQ-021: Enqueue and dequeue in the same cycle SHALL leave occupancy unchanged; the full buffer SHALL still accept the reserved response.
- REQ-022: On redirect high at a rising edge, the block SHALL empty the buffer (inst_valid low next cycle) and load fetch_pc with {redirect_pc[XLEN-1:2], 2'b00}.
- REQ-023: On redirect, the outstanding request count, including any request transferring that same cycle, SHALL be moved to a discard counter.
- REQ-024: Responses arriving while the discard counter is nonzero SHALL be dropped, decrementing the counter; requests MAY issue while discards are pending.
- REQ-025: The outstanding counter SHALL increment on a request transfer and decrement on a non-discarded response, both in the same cycle when both occur; it SHALL never exceed DEPTH.
- REQ-026: redirect SHALL take priority over enqueue, dequeue and issue in the same cycle; the head presented that cycle SHALL be treated as not consumed.
- REQ-027: A response with no outstanding or discard count SHALL be ignored, and no counter SHALL underflow.

Reset
- REQ-028: While rst is high, regardless of clk, fetch_pc SHALL be RESET_PC, all pointers and counters 0, inst_valid 0 and imem_req_valid 0.
- REQ-029: inst_data, inst_pc and inst_pc_plus4 SHALL read 0 while the buffer is empty after reset.
- REQ-030: The first request SHALL be raised on the first rising edge after rst falls, with address RESET_PC.
- REQ-031: Reset asserted mid-operation SHALL discard all buffered and in-flight state; stale responses arriving after reset SHALL be ignored per REQ-027.

Verification
- REQ-032: The bench SHALL check streaming: 1-cycle memory and inst_ready held at 1 -> inst_pc sequence 0x0, 0x4, 0x8, ... with matching data and no bubbles after fill.
- REQ-033: The bench SHALL check back-pressure: inst_ready at 0 -> exactly DEPTH (4) entries fill, imem_req_valid falls and stays 0, and the order is intact on release.
- REQ-034: The bench SHALL check a redirect with 2 outstanding: redirect_pc 0x103 -> the next 2 responses are dropped and the first delivered inst_pc is 0x100.
- REQ-035: The bench SHALL check simultaneous redirect, response and dequeue -> the buffer is empty next cycle and the response is neither enqueued nor counted as delivered.
- REQ-036: The bench SHALL check wrap-around: RESET_PC 0xFFFFFFF8 -> inst_pc sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x0.
- REQ-037: The bench SHALL check asynchronous reset between clock edges: all outputs are 0 immediately, and after release the first imem_req_addr is RESET_PC.
